cpu_cycle_sequencer: RTL and testbench

- Upstream of the instruction decoder in the CPU core.
- Generates the phase strobes (clk_ph1, clk_ph2) from sys_clock, maintains the per-instruction cycle counter and owns the instruction register (IR).
- Loads opcodes from the data bus and injects BRK (8'h00) for RESET/NMI/IRQ sequences.
- The decoder samples cycle/IR on the same sys_clock edge where clk_ph2 is high; both blocks update together, so both see pre-edge values.

---
 rtl/cpu_cycle_sequencer.sv | 158 +++++++++++++++
 tb/tb_cpu_cycle_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_cycle_sequencer.sv
// CPU cycle sequencer: phase strobes, per-instruction cycle counter, IR load and BRK injection.
// Define CPU_INT_INJECT_EN to enable NMI/IRQ capture and injection; RESET injection is always present.
module cpu_cycle_sequencer #(
    parameter int unsigned CLK_DIV   = 12,
    parameter int unsigned MAX_CYCLE = 7
) (
    input  logic       sys_clock,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       last_cycle,
    input  logic       rdy,
    input  logic       nmi_n,
    input  logic       irq_n,
    input  logic       i_flag,
    output logic       clk_ph1,
    output logic       clk_ph2,
    output logic [2:0] cycle,
    output logic [7:0] IR,
    output logic [1:0] int_src,
    output logic       jam
);

    localparam int unsigned     DIV_W     = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] PH1_AT   = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [DIV_W-1:0] PH2_AT   = DIV_W'(CLK_DIV - 1);
    localparam logic [2:0]      MAX_CYC   = 3'(MAX_CYCLE);
    localparam logic [7:0]      OP_BRK    = 8'h00;
    localparam logic [1:0]      SRC_NONE  = 2'b00;
    localparam logic [1:0]      SRC_RESET = 2'b11;

    logic [DIV_W-1:0] r_div_cnt;
    logic [DIV_W-1:0] w_div_nxt;
    logic             r_ph1;
    logic             r_ph2;

    logic [2:0] r_cycle;
    logic [7:0] r_ir;
    logic [1:0] r_int_src;
    logic       r_jam;
    logic [2:0] w_cycle_nxt;
    logic [7:0] w_ir_nxt;
    logic [1:0] w_int_src_nxt;
    logic       w_jam_nxt;

    // Sequencing advances only on the edge that ends a CPU cycle.
    logic w_seq_edge;
    assign w_seq_edge = r_ph2 & ~r_jam;

    assign w_div_nxt = (r_div_cnt == PH2_AT) ? '0 : r_div_cnt + 1'b1;

    always_ff @(posedge sys_clock or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_ph1     <= 1'b0;
            r_ph2     <= 1'b0;
        end else begin
            r_div_cnt <= w_div_nxt;
            r_ph1     <= (w_div_nxt == PH1_AT);
            r_ph2     <= (w_div_nxt == PH2_AT);
        end
    end

`ifdef CPU_INT_INJECT_EN
    localparam logic [1:0] SRC_IRQ = 2'b01;
    localparam logic [1:0] SRC_NMI = 2'b10;

    logic r_nmi_sync;
    logic r_nmi_pend;
    logic w_nmi_sync_nxt;
    logic w_nmi_pend_nxt;
    logic w_nmi_take;

    always_comb begin
        w_nmi_sync_nxt = r_nmi_sync;
        w_nmi_pend_nxt = r_nmi_pend;
        if (w_seq_edge) begin
            w_nmi_sync_nxt = nmi_n;
            if (w_nmi_take) begin
                w_nmi_pend_nxt = 1'b0;
            end
            // A fresh falling edge on the consuming load must not be lost.
            if (r_nmi_sync && !nmi_n) begin
                w_nmi_pend_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clock or posedge rst) begin
        if (rst) begin
            r_nmi_sync <= 1'b1;
            r_nmi_pend <= 1'b0;
        end else begin
            r_nmi_sync <= w_nmi_sync_nxt;
            r_nmi_pend <= w_nmi_pend_nxt;
        end
    end
`else
    logic w_unused_int;
    assign w_unused_int = ^{nmi_n, irq_n, i_flag};
`endif

    always_comb begin
        w_cycle_nxt   = r_cycle;
        w_ir_nxt      = r_ir;
        w_int_src_nxt = r_int_src;
        w_jam_nxt     = r_jam;
`ifdef CPU_INT_INJECT_EN
        w_nmi_take    = 1'b0;
`endif
        if (w_seq_edge && rdy) begin
            if (last_cycle) begin
                w_cycle_nxt = '0;
`ifdef CPU_INT_INJECT_EN
                if (r_nmi_pend) begin
                    w_nmi_take    = 1'b1;
                    w_ir_nxt      = OP_BRK;
                    w_int_src_nxt = SRC_NMI;
                end else if (!irq_n && !i_flag) begin
                    w_ir_nxt      = OP_BRK;
                    w_int_src_nxt = SRC_IRQ;
                end else begin
                    w_ir_nxt      = data_in;
                    w_int_src_nxt = SRC_NONE;
                end
`else
                w_ir_nxt      = data_in;
                w_int_src_nxt = SRC_NONE;
`endif
            end else if (r_cycle < MAX_CYC) begin
                w_cycle_nxt = r_cycle + 3'd1;
            end else begin
                w_jam_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clock or posedge rst) begin
        if (rst) begin
            r_cycle   <= '0;
            r_ir      <= OP_BRK;
            r_int_src <= SRC_RESET;
            r_jam     <= 1'b0;
        end else begin
            r_cycle   <= w_cycle_nxt;
            r_ir      <= w_ir_nxt;
            r_int_src <= w_int_src_nxt;
            r_jam     <= w_jam_nxt;
        end
    end

    assign clk_ph1 = r_ph1;
    assign clk_ph2 = r_ph2;
    assign cycle   = r_cycle;
    assign IR      = r_ir;
    assign int_src = r_int_src;
    assign jam     = r_jam;

endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// Self-checking bench for cpu_cycle_sequencer; expectations flow through a scoreboard queue.
// Interrupt expectations follow CPU_INT_INJECT_EN when it is defined for the build.
module tb_cpu_cycle_sequencer;

    localparam int unsigned CLK_DIV = 12;

`ifdef CPU_INT_INJECT_EN
    localparam bit INJ = 1'b1;
`else
    localparam bit INJ = 1'b0;
`endif

    typedef struct packed {
        logic       lc;
        logic       r;
        logic       nmi;
        logic       irq;
        logic       ifl;
        logic [7:0] d;
    } stim_t;

    typedef struct packed {
        logic [2:0] cyc;
        logic [7:0] ir;
        logic [1:0] src;
        logic       jam;
    } exp_t;

    logic       sys_clock;
    logic       rst;
    logic [7:0] data_in;
    logic       last_cycle;
    logic       rdy;
    logic       nmi_n;
    logic       irq_n;
    logic       i_flag;
    logic       clk_ph1;
    logic       clk_ph2;
    logic [2:0] cycle;
    logic [7:0] IR;
    logic [1:0] int_src;
    logic       jam;

    int   n_pass;
    int   n_total;
    exp_t exp_q[$];
    logic [1:0] ph_q[$];

    cpu_cycle_sequencer #(
        .CLK_DIV  (CLK_DIV),
        .MAX_CYCLE(7)
    ) dut (
        .sys_clock (sys_clock),
        .rst       (rst),
        .data_in   (data_in),
        .last_cycle(last_cycle),
        .rdy       (rdy),
        .nmi_n     (nmi_n),
        .irq_n     (irq_n),
        .i_flag    (i_flag),
        .clk_ph1   (clk_ph1),
        .clk_ph2   (clk_ph2),
        .cycle     (cycle),
        .IR        (IR),
        .int_src   (int_src),
        .jam       (jam)
    );

    initial sys_clock = 1'b0;
    always #5 sys_clock = ~sys_clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, need finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic stim_t mk(input logic lc, input logic r, input logic nmi, input logic irq,
                                 input logic ifl, input logic [7:0] d);
        return {lc, r, nmi, irq, ifl, d};
    endfunction

    function automatic exp_t mke(input logic [2:0] cyc, input logic [7:0] ir,
                                 input logic [1:0] src, input logic jm);
        return {cyc, ir, src, jm};
    endfunction

    // Step until the sample point where clk_ph2 is high; the first edge commits a pending strobe.
    task automatic to_ph2();
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 2 * CLK_DIV; i++) begin
            @(posedge sys_clock);
            #1;
            if (clk_ph2 === 1'b1) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) begin
            n_total++;
            $display("FAIL ph2_timeout: clk_ph2 got 0 for %0d clocks, need 1", 2 * CLK_DIV);
        end
    endtask

    task automatic strobe(input stim_t s);
        last_cycle = s.lc;
        rdy        = s.r;
        nmi_n      = s.nmi;
        irq_n      = s.irq;
        i_flag     = s.ifl;
        data_in    = s.d;
        to_ph2();
    endtask

    task automatic test_reset();
        exp_t got;
        exp_t want;
        rst        = 1'b1;
        rdy        = 1'b0;
        last_cycle = 1'b0;
        nmi_n      = 1'b1;
        irq_n      = 1'b1;
        i_flag     = 1'b0;
        data_in    = 8'hFF;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(mke(3'd0, 8'h00, 2'b11, 1'b0));
            if (k == 0) #1;
            else begin
                repeat (3) @(posedge sys_clock);
                #1;
            end
            got  = {cycle, IR, int_src, jam};
            want = exp_q.pop_front();
            n_total++;
            if (got !== want || clk_ph1 !== 1'b0 || clk_ph2 !== 1'b0)
                $display("FAIL reset[%0d]: got cyc=%0d ir=%h src=%b jam=%b ph=%b%b, need cyc=%0d ir=%h src=%b jam=%b ph=00",
                         k, got.cyc, got.ir, got.src, got.jam, clk_ph1, clk_ph2,
                         want.cyc, want.ir, want.src, want.jam);
            else n_pass++;
        end
        rst = 1'b0;
    endtask

    task automatic test_divider();
        logic [1:0] want;
        for (int e = 1; e <= 48; e++) begin
            ph_q.push_back({(e % 12) == 5, (e % 12) == 11});
            @(posedge sys_clock);
            #1;
            want = ph_q.pop_front();
            n_total++;
            if ({clk_ph1, clk_ph2} !== want)
                $display("FAIL divider[clk %0d]: got ph1/ph2=%b%b, need %b%b",
                         e, clk_ph1, clk_ph2, want[1], want[0]);
            else n_pass++;
        end
    endtask

    task automatic pulse_reset();
        @(posedge sys_clock);
        #1;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_sequence();
        stim_t st[7];
        exp_t  ex[7];
        exp_t  got;
        exp_t  want;
        to_ph2();
        exp_q.push_back(mke(3'd0, 8'h00, 2'b11, 1'b0));
        got  = {cycle, IR, int_src, jam};
        want = exp_q.pop_front();
        n_total++;
        if (got !== want)
            $display("FAIL seq_start: got cyc=%0d ir=%h src=%b jam=%b, need cyc=%0d ir=%h src=%b jam=%b",
                     got.cyc, got.ir, got.src, got.jam, want.cyc, want.ir, want.src, want.jam);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            st[i] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF);
            ex[i] = mke(3'(i + 1), 8'h00, 2'b11, 1'b0);
        end
        st[6] = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA9);
        ex[6] = mke(3'd0, 8'hA9, 2'b00, 1'b0);
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(ex[i]);
            strobe(st[i]);
            got  = {cycle, IR, int_src, jam};
            want = exp_q.pop_front();
            n_total++;
            if (got !== want)
                $display("FAIL sequence[%0d]: got cyc=%0d ir=%h src=%b jam=%b, need cyc=%0d ir=%h src=%b jam=%b",
                         i, got.cyc, got.ir, got.src, got.jam, want.cyc, want.ir, want.src, want.jam);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        stim_t st[5];
        exp_t  ex[5];
        exp_t  got;
        exp_t  want;
        for (int i = 0; i < 3; i++) begin
            st[i] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF);
            ex[i] = mke(3'd0, 8'hA9, 2'b00, 1'b0);
        end
        st[3] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF);
        ex[3] = mke(3'd1, 8'hA9, 2'b00, 1'b0);
        // Stall outranks last_cycle: no load may happen.
        st[4] = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF);
        ex[4] = mke(3'd1, 8'hA9, 2'b00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(ex[i]);
            strobe(st[i]);
            got  = {cycle, IR, int_src, jam};
            want = exp_q.pop_front();
            n_total++;
            if (got !== want)
                $display("FAIL stall[%0d]: got cyc=%0d ir=%h src=%b jam=%b, need cyc=%0d ir=%h src=%b jam=%b",
                         i, got.cyc, got.ir, got.src, got.jam, want.cyc, want.ir, want.src, want.jam);
            else n_pass++;
        end
    endtask

    task automatic test_nmi_irq();
        stim_t st[10];
        exp_t  ex[10];
        exp_t  got;
        exp_t  want;
        st[0] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
        ex[0] = mke(3'd2, 8'hA9, 2'b00, 1'b0);
        st[1] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hEA);
        ex[1] = mke(3'd0, INJ ? 8'h00 : 8'hEA, INJ ? 2'b10 : 2'b00, 1'b0);
        st[2] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hEA);
        ex[2] = mke(3'd0, INJ ? 8'h00 : 8'hEA, INJ ? 2'b01 : 2'b00, 1'b0);
        st[3] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h4C);
        ex[3] = mke(3'd0, 8'h4C, 2'b00, 1'b0);
        st[4] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF);
        ex[4] = mke(3'd1, 8'h4C, 2'b00, 1'b0);
        st[5] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF);
        ex[5] = mke(3'd2, 8'h4C, 2'b00, 1'b0);
        st[6] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF);
        ex[6] = mke(3'd3, 8'h4C, 2'b00, 1'b0);
        // New NMI edge on the very load that consumes the pending one.
        st[7] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h20);
        ex[7] = mke(3'd0, INJ ? 8'h00 : 8'h20, INJ ? 2'b10 : 2'b00, 1'b0);
        st[8] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h20);
        ex[8] = mke(3'd0, INJ ? 8'h00 : 8'h20, INJ ? 2'b10 : 2'b00, 1'b0);
        st[9] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h60);
        ex[9] = mke(3'd0, 8'h60, 2'b00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(ex[i]);
            strobe(st[i]);
            got  = {cycle, IR, int_src, jam};
            want = exp_q.pop_front();
            n_total++;
            if (got !== want)
                $display("FAIL nmi_irq[%0d]: got cyc=%0d ir=%h src=%b jam=%b, need cyc=%0d ir=%h src=%b jam=%b",
                         i, got.cyc, got.ir, got.src, got.jam, want.cyc, want.ir, want.src, want.jam);
            else n_pass++;
        end
        nmi_n  = 1'b1;
        irq_n  = 1'b1;
        i_flag = 1'b0;
    endtask

    task automatic test_jam();
        exp_t got;
        exp_t want;
        for (int i = 0; i < 11; i++) begin
            if (i < 7) exp_q.push_back(mke(3'(i + 1), 8'h60, 2'b00, 1'b0));
            else       exp_q.push_back(mke(3'd7, 8'h60, 2'b00, 1'b1));
            strobe(mk(i >= 8, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA9));
            got  = {cycle, IR, int_src, jam};
            want = exp_q.pop_front();
            n_total++;
            if (got !== want)
                $display("FAIL jam[%0d]: got cyc=%0d ir=%h src=%b jam=%b, need cyc=%0d ir=%h src=%b jam=%b",
                         i, got.cyc, got.ir, got.src, got.jam, want.cyc, want.ir, want.src, want.jam);
            else n_pass++;
        end
        exp_q.push_back(mke(3'd0, 8'h00, 2'b11, 1'b0));
        rst = 1'b1;
        #2;
        got  = {cycle, IR, int_src, jam};
        want = exp_q.pop_front();
        n_total++;
        if (got !== want)
            $display("FAIL jam_clear: got cyc=%0d ir=%h src=%b jam=%b, need cyc=%0d ir=%h src=%b jam=%b",
                     got.cyc, got.ir, got.src, got.jam, want.cyc, want.ir, want.src, want.jam);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_async_reset();
        exp_t got;
        exp_t want;
        to_ph2();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mke(3'(i), 8'hA9, 2'b00, 1'b0));
            strobe(mk(i == 0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA9));
            got  = {cycle, IR, int_src, jam};
            want = exp_q.pop_front();
            n_total++;
            if (got !== want)
                $display("FAIL async_pre[%0d]: got cyc=%0d ir=%h src=%b jam=%b, need cyc=%0d ir=%h src=%b jam=%b",
                         i, got.cyc, got.ir, got.src, got.jam, want.cyc, want.ir, want.src, want.jam);
            else n_pass++;
        end
        // clk_ph2 is high here; reset must drop everything before the next edge.
        exp_q.push_back(mke(3'd0, 8'h00, 2'b11, 1'b0));
        rst = 1'b1;
        #2;
        got  = {cycle, IR, int_src, jam};
        want = exp_q.pop_front();
        n_total++;
        if (got !== want || clk_ph1 !== 1'b0 || clk_ph2 !== 1'b0)
            $display("FAIL async_reset: got cyc=%0d ir=%h src=%b jam=%b ph=%b%b, need cyc=%0d ir=%h src=%b jam=%b ph=00",
                     got.cyc, got.ir, got.src, got.jam, clk_ph1, clk_ph2,
                     want.cyc, want.ir, want.src, want.jam);
        else n_pass++;
        rst = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_divider();
        pulse_reset();
        rdy = 1'b1;
        test_sequence();
        test_stall();
        test_nmi_irq();
        test_jam();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
